// File: rtl/e5m2_mul_arb_if.sv
// Bundle of requester, multiplier and response signals for e5m2_mul_arb.
// slave is the arbiter's view; master is the environment's view.
// Widths follow NREQ/IDW so the interface matches the arbiter instance.
interface e5m2_mul_arb_if #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]   req_valid_i;
  logic [NREQ-1:0]   req_ready_o;
  logic [NREQ*8-1:0] req_a_i;
  logic [NREQ*8-1:0] req_b_i;
  logic [7:0]        mul_a_o;
  logic [7:0]        mul_b_o;
  logic [7:0]        mul_c_i;
  logic              mul_inf_i;
  logic              mul_nan_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [IDW-1:0]    rsp_id_o;
  logic [7:0]        rsp_c_o;
  logic              rsp_inf_o;
  logic              rsp_nan_o;

  modport slave (
    input  req_valid_i, req_a_i, req_b_i, mul_c_i, mul_inf_i, mul_nan_i, rsp_ready_i,
    output req_ready_o, mul_a_o, mul_b_o, rsp_valid_o, rsp_id_o, rsp_c_o, rsp_inf_o, rsp_nan_o
  );

  modport master (
    output req_valid_i, req_a_i, req_b_i, mul_c_i, mul_inf_i, mul_nan_i, rsp_ready_i,
    input  req_ready_o, mul_a_o, mul_b_o, rsp_valid_o, rsp_id_o, rsp_c_o, rsp_inf_o, rsp_nan_o
  );
endinterface

// File: rtl/e5m2_mul_arb.sv
// Round-robin share of one external combinational E5M2 multiplier among NREQ requesters.
// Latency: 1 cycle from operand handshake to rsp_valid_o; 1 result/cycle sustained.
// Backpressure: a stalled response (valid && !ready) blocks all req_ready_o; optional
// statistics counters are built only with E5M2_MUL_ARB_STATS_EN defined.
module e5m2_mul_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic        clk_i,
  input  logic        rst_ni,
`ifdef E5M2_MUL_ARB_STATS_EN
  output logic [15:0] stat_ops_o,
  output logic [15:0] stat_nan_o,
`endif
  e5m2_mul_arb_if.slave bus
);

  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] grant;
  logic           any_vld;
  logic           load_en;
  logic           hs;

  // Result register may take new data when empty or being drained this cycle.
  assign load_en = !bus.rsp_valid_o || bus.rsp_ready_i;
  assign hs      = any_vld && load_en;

  // Cyclic search for the first valid requester starting at the pointer.
  always_comb begin
    grant   = ptr_q;
    any_vld = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!any_vld && bus.req_valid_i[(int'(ptr_q) + k) % NREQ]) begin
        grant   = IDW'((int'(ptr_q) + k) % NREQ);
        any_vld = 1'b1;
      end
    end
  end

  // Steer the granted operands to the multiplier and raise that requester's ready only.
  always_comb begin
    bus.req_ready_o = '0;
    bus.mul_a_o     = 8'h00;
    bus.mul_b_o     = 8'h00;
    if (any_vld) begin
      bus.mul_a_o = bus.req_a_i[grant*8 +: 8];
      bus.mul_b_o = bus.req_b_i[grant*8 +: 8];
      if (load_en) bus.req_ready_o[grant] = 1'b1;
    end
  end

  // Capture the product on handshake; drain on downstream accept; advance pointer past the winner.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bus.rsp_valid_o <= 1'b0;
      bus.rsp_c_o     <= 8'h00;
      bus.rsp_inf_o   <= 1'b0;
      bus.rsp_nan_o   <= 1'b0;
      bus.rsp_id_o    <= '0;
      ptr_q           <= '0;
    end else if (hs) begin
      bus.rsp_valid_o <= 1'b1;
      bus.rsp_c_o     <= bus.mul_c_i;
      bus.rsp_inf_o   <= bus.mul_inf_i;
      bus.rsp_nan_o   <= bus.mul_nan_i;
      bus.rsp_id_o    <= grant;
      ptr_q           <= (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
    end else if (bus.rsp_ready_i) begin
      bus.rsp_valid_o <= 1'b0;
    end
  end

`ifdef E5M2_MUL_ARB_STATS_EN
  // Saturating counts of handshakes and of NaN products captured.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_ops_o <= 16'h0000;
      stat_nan_o <= 16'h0000;
    end else if (hs) begin
      if (stat_ops_o != 16'hFFFF) stat_ops_o <= stat_ops_o + 16'd1;
      if (bus.mul_nan_i && stat_nan_o != 16'hFFFF) stat_nan_o <= stat_nan_o + 16'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_e5m2_mul_arb.sv
// Directed bench for e5m2_mul_arb with a queue scoreboard and an independent response monitor.
// The multiplier is a small table of hand-computed E5M2 products.
module tb_e5m2_mul_arb;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  e5m2_mul_arb_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

`ifdef E5M2_MUL_ARB_STATS_EN
  logic [15:0] stat_ops;
  logic [15:0] stat_nan;
  logic [15:0] nan_before;
`endif

  e5m2_mul_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
`ifdef E5M2_MUL_ARB_STATS_EN
    .stat_ops_o (stat_ops),
    .stat_nan_o (stat_nan),
`endif
    .bus        (bus)
  );

  // Hand-computed E5M2 products for the operand pairs used below.
  always_comb begin
    bus.mul_c_i   = 8'h00;
    bus.mul_inf_i = 1'b0;
    bus.mul_nan_i = 1'b0;
    case ({bus.mul_a_o, bus.mul_b_o})
      16'h3C3C: bus.mul_c_i = 8'h3C;               // 1.0 * 1.0 = 1.0
      16'h4040: bus.mul_c_i = 8'h44;               // 2.0 * 2.0 = 4.0
      16'h3C40: bus.mul_c_i = 8'h40;               // 1.0 * 2.0 = 2.0
      16'h4440: bus.mul_c_i = 8'h48;               // 4.0 * 2.0 = 8.0
      16'h7D3C: begin bus.mul_c_i = 8'h7D; bus.mul_nan_i = 1'b1; end
      16'h7C3C: begin bus.mul_c_i = 8'h7C; bus.mul_inf_i = 1'b1; end
      default:  bus.mul_c_i = 8'h00;
    endcase
  end

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [7:0]     c;
    logic           inf;
    logic           nan;
  } rsp_t;

  rsp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int id, input logic [7:0] c, input logic inf, input logic nan);
    rsp_t e;
    e.id  = IDW'(id);
    e.c   = c;
    e.inf = inf;
    e.nan = nan;
    sb.push_back(e);
  endtask

  task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
    bus.req_a_i[i*8 +: 8] = a;
    bus.req_b_i[i*8 +: 8] = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pops one expected response for every response the DUT hands downstream.
  task automatic monitor();
    rsp_t e;
    rsp_t act;
    forever begin
      @(negedge clk);
      if (rst_n && bus.rsp_valid_o && bus.rsp_ready_i) begin
        act = {bus.rsp_id_o, bus.rsp_c_o, bus.rsp_inf_o, bus.rsp_nan_o};
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 32'(act), 32'h0);
          if (act == '0) begin
            n_fail++;
            $display("FAIL unexpected_rsp: response with empty scoreboard at %0t", $time);
          end
        end else begin
          e = sb.pop_front();
          chk("rsp", 32'(act), 32'(e));
        end
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    bus.req_valid_i = '0;
    bus.req_a_i     = '0;
    bus.req_b_i     = '0;
    bus.rsp_ready_i = 1'b1;
    set_ops(0, 8'h3C, 8'h3C);
    set_ops(1, 8'h40, 8'h40);
    set_ops(2, 8'h3C, 8'h40);
    set_ops(3, 8'h44, 8'h40);

    // Reset state.
    repeat (2) tick();
    chk("rst_valid", 32'(bus.rsp_valid_o), 32'h0);
    chk("rst_c", 32'(bus.rsp_c_o), 32'h0);
    chk("rst_id", 32'(bus.rsp_id_o), 32'h0);
    chk("rst_ptr", 32'(dut.ptr_q), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(bus.req_ready_o), 32'h0);
    chk("idle_mul_a", 32'(bus.mul_a_o), 32'h0);

    // Single request from requester 2.
    tick();
    bus.req_valid_i = 4'b0100;
    push(2, 8'h40, 1'b0, 1'b0);
    @(negedge clk);
    chk("single_ready", 32'(bus.req_ready_o), 32'h4);
    chk("single_mul_a", 32'(bus.mul_a_o), 32'h3C);
    chk("single_mul_b", 32'(bus.mul_b_o), 32'h40);
    tick();
    bus.req_valid_i = '0;
    chk("single_valid", 32'(bus.rsp_valid_o), 32'h1);
    chk("single_id", 32'(bus.rsp_id_o), 32'h2);
    chk("single_c", 32'(bus.rsp_c_o), 32'h40);
    chk("single_ptr", 32'(dut.ptr_q), 32'h3);

    // Requester 3 alone wraps the pointer to 0.
    bus.req_valid_i = 4'b1000;
    push(3, 8'h48, 1'b0, 1'b0);
    tick();
    bus.req_valid_i = '0;
    chk("wrap_ptr", 32'(dut.ptr_q), 32'h0);

    // Fairness: all four held valid, one grant per cycle in rotation.
    bus.req_valid_i = 4'b1111;
    push(0, 8'h3C, 1'b0, 1'b0);
    push(1, 8'h44, 1'b0, 1'b0);
    push(2, 8'h40, 1'b0, 1'b0);
    push(3, 8'h48, 1'b0, 1'b0);
    push(0, 8'h3C, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("fair_valid", 32'(bus.rsp_valid_o), 32'h1);
    end
    bus.req_valid_i = '0;
    chk("fair_ptr", 32'(dut.ptr_q), 32'h1);
    tick();

    // Backpressure: pending result blocks all requesters; release captures the same cycle.
    bus.rsp_ready_i = 1'b0;
    bus.req_valid_i = 4'b0010;
    push(1, 8'h44, 1'b0, 1'b0);
    tick();
    bus.req_valid_i = 4'b0100;
    push(2, 8'h40, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_ready", 32'(bus.req_ready_o), 32'h0);
      chk("bp_hold", 32'({bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_c_o}), 32'({1'b1, 2'd1, 8'h44}));
      tick();
    end
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(bus.req_ready_o), 32'h4);
    tick();
    bus.req_valid_i = '0;
    chk("bp_id", 32'(bus.rsp_id_o), 32'h2);
    chk("bp_ptr", 32'(dut.ptr_q), 32'h3);

    // NaN and infinity passthrough.
`ifdef E5M2_MUL_ARB_STATS_EN
    nan_before = stat_nan;
`endif
    set_ops(3, 8'h7D, 8'h3C);
    bus.req_valid_i = 4'b1000;
    push(3, 8'h7D, 1'b0, 1'b1);
    tick();
    bus.req_valid_i = '0;
    chk("nan_flag", 32'({bus.rsp_nan_o, bus.rsp_inf_o}), 32'h2);
`ifdef E5M2_MUL_ARB_STATS_EN
    chk("stat_nan", 32'(stat_nan), 32'(nan_before + 16'd1));
`endif
    set_ops(0, 8'h7C, 8'h3C);
    bus.req_valid_i = 4'b0001;
    push(0, 8'h7C, 1'b1, 1'b0);
    tick();
    bus.req_valid_i = '0;
    chk("inf_flag", 32'({bus.rsp_nan_o, bus.rsp_inf_o}), 32'h1);
    tick();

    // Reset while a result is pending: it is dropped, then arbitration restarts cleanly.
    bus.rsp_ready_i = 1'b0;
    bus.req_valid_i = 4'b0010;
    tick();
    bus.req_valid_i = '0;
    chk("pre_rst_valid", 32'(bus.rsp_valid_o), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus.rsp_valid_o), 32'h0);
    chk("async_rst_ptr", 32'(dut.ptr_q), 32'h0);
    chk("async_rst_c", 32'(bus.rsp_c_o), 32'h0);
    tick();
    rst_n = 1'b1;
    bus.rsp_ready_i = 1'b1;
    set_ops(3, 8'h44, 8'h40);
    bus.req_valid_i = 4'b1000;
    push(3, 8'h48, 1'b0, 1'b0);
    tick();
    bus.req_valid_i = '0;
    chk("post_rst_id", 32'(bus.rsp_id_o), 32'h3);
    chk("post_rst_ptr", 32'(dut.ptr_q), 32'h0);
    chk("post_rst_valid", 32'(bus.rsp_valid_o), 32'h1);
    tick();

`ifdef E5M2_MUL_ARB_STATS_EN
    // Operation counter saturates after more than 65535 handshakes.
    set_ops(0, 8'h3C, 8'h3C);
    for (int i = 0; i < 65540; i++) begin
      case (i % 4)
        0: push(0, 8'h3C, 1'b0, 1'b0);
        1: push(1, 8'h44, 1'b0, 1'b0);
        2: push(2, 8'h40, 1'b0, 1'b0);
        default: push(3, 8'h48, 1'b0, 1'b0);
      endcase
    end
    bus.req_valid_i = 4'b1111;
    repeat (65540) tick();
    bus.req_valid_i = '0;
    chk("stat_ops_sat", 32'(stat_ops), 32'hFFFF);
`endif

    // Every expected response must have been delivered.
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    chk("sb_drain", 32'(sb.size()), 32'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/e5m2_mul_arb.md
E5M2_MUL_ARB -- requirements
Module: e5m2_mul_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing one E5M2 multiplier (2..8).
REQ-002 SHALL have parameter IDW, default $clog2(NREQ), width of the requester index.
REQ-003 SHALL have clk_i  input  1  single clock; all state on rising edge.
REQ-004 SHALL have rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have req_valid_i  input  NREQ  per-requester operand valid.
REQ-006 SHALL have req_ready_o  output  NREQ  per-requester operand accept.
REQ-007 SHALL have req_a_i  input  NREQ*8  E5M2 operand A per requester; requester i uses bits [8i+7:8i].
REQ-008 SHALL have req_b_i  input  NREQ*8  E5M2 operand B per requester, packed the same way.
REQ-009 SHALL have mul_a_o  output  8  operand A driven to the external combinational multiplier.
REQ-010 SHALL have mul_b_o  output  8  operand B driven to the multiplier.
REQ-011 SHALL have mul_c_i  input  8  multiplier E5M2 product.
REQ-012 SHALL have mul_inf_i  input  1  multiplier infinity flag.
REQ-013 SHALL have mul_nan_i  input  1  multiplier NaN flag.
REQ-014 SHALL have rsp_valid_o  output  1  registered result valid.
REQ-015 SHALL have rsp_ready_i  input  1  downstream accept.
REQ-016 SHALL have rsp_id_o  output  IDW  index of the requester that owns the result.
REQ-017 SHALL have rsp_c_o  output  8, rsp_inf_o  output  1, rsp_nan_o  output  1  registered product and flags.

Function
REQ-018 SHALL compute load_en = !rsp_valid_o || rsp_ready_i; the result register accepts new data only when load_en is 1.
REQ-019 SHALL select grant index g round-robin: first i with req_valid_i[i]=1, searching cyclically from ptr_q upward.
REQ-020 SHALL drive mul_a_o/mul_b_o with the operands of g whenever any valid is set, and with 0x00 otherwise.
REQ-021 SHALL assert req_ready_o[g] only when at least one valid is set and load_en=1; all other ready bits SHALL be 0 (one-hot or zero).
REQ-022 SHALL treat a handshake (req_valid_i[g] & req_ready_o[g]) as a capture: rsp_valid_o<=1, rsp_c_o<=mul_c_i, rsp_inf_o<=mul_inf_i, rsp_nan_o<=mul_nan_i, rsp_id_o<=g, ptr_q<=(g+1) mod NREQ.
REQ-023 SHALL clear rsp_valid_o when rsp_ready_i=1 and no handshake occurs in the same cycle; the result data SHALL hold otherwise.
REQ-024 SHALL, with rsp_valid_o=1 and rsp_ready_i=0, hold all response outputs stable and deassert all req_ready_o.
REQ-025 SHALL support simultaneous response drain and new capture in one cycle, giving 1 result/cycle throughput and 1-cycle latency from handshake to rsp_valid_o.
REQ-026 SHALL leave ptr_q unchanged in cycles without a handshake; ptr_q wraps from NREQ-1 to 0.
REQ-027 SHALL never let req_valid_i depend on req_ready_o; requesters hold valid and operands until accepted.

Reset
REQ-028 SHALL, while rst_ni=0, force rsp_valid_o=0, rsp_c_o=0x00, rsp_inf_o=0, rsp_nan_o=0, rsp_id_o=0, ptr_q=0, asynchronously.
REQ-029 SHALL drop an in-flight unconsumed result on reset, with no response replayed after reset release.
REQ-030 SHALL grant normally from the first rising edge after rst_ni deasserts.

Configuration
REQ-031 SHALL, with macro E5M2_MUL_ARB_STATS_EN defined, add outputs stat_ops_o (16 bits; counts handshakes) and stat_nan_o (16 bits; counts captures with mul_nan_i=1), both saturating at 0xFFFF and reset to 0.
REQ-032 SHALL, without E5M2_MUL_ARB_STATS_EN, omit those ports and counters entirely, leaving all other behaviour identical.

Verification
REQ-033 SHALL test single request: req 2 valid, A=0x3C (1.0), B=0x40 (2.0), rsp_ready_i=1 -> next cycle rsp_valid_o=1, rsp_id_o=2, rsp_c_o=0x40, ptr_q=3.
REQ-034 SHALL test fairness: all 4 valid continuously, rsp_ready_i=1 -> rsp_id_o sequence 0,1,2,3,0 on consecutive cycles.
REQ-035 SHALL test backpressure: result pending, rsp_ready_i=0 for 5 cycles -> req_ready_o=0000, response fields unchanged; on rsp_ready_i=1, new capture that same cycle.
REQ-036 SHALL test NaN passthrough: A=0x7D, B=0x3C -> rsp_nan_o=1, rsp_inf_o=0; with stats enabled, stat_nan_o increments by 1.
REQ-037 SHALL test reset mid-operation: rst_ni low while rsp_valid_o=1 -> rsp_valid_o=0 immediately; after release with req 3 valid, first rsp_id_o=3 and ptr_q=0.
REQ-038 SHALL test counter saturation (stats enabled): force 65,536 handshakes -> stat_ops_o stays 0xFFFF.
